memoria_de_dados_multiciclo: RTL and testbench

//  Parametrised data memory for the MIPS datapath with byte/halfword/word access and sign/zero-extended loads.

---
 rtl/memoria_de_dados_multiciclo.sv | 154 +++++++++++++++
 tb/tb_memoria_de_dados_multiciclo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_de_dados_multiciclo.sv
// Multi-cycle data memory for the MIPS datapath.
// Byte/half/word access with req/ready/done handshake and error flag.
module memoria_de_dados_multiciclo #(
    parameter int MEM_SIZE    = 256,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  memWrite,
    input  logic [1:0]            tamanho,
    input  logic                  sinal,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [31:0]           dado_Escrito,
    output logic                  ready,
    output logic                  done,
    output logic [31:0]           dado_Lido,
    output logic                  erro
);

    localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t state, state_next;

    logic [3:0]            cnt;
    logic                  we_q;
    logic                  sg_q;
    logic [1:0]            tam_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wd_q;

    logic [31:0] mem [MEM_SIZE];

    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          mis;
    logic          oob;
    logic          err;
    logic [31:0]   word;
    logic [31:0]   rdata;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic [31:0]   wword;

    assign idx  = addr_q[IW+1:2];
    assign lane = addr_q[1:0];
    assign oob  = (addr_q >> 2) >= ADDR_WIDTH'(MEM_SIZE);
    assign err  = mis | oob;
    assign word = mem[idx];

    // Next state and handshake ready
    always_comb begin
        state_next = state;
        ready      = (state == S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (req)
                    state_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd1)
                    state_next = S_ACCESS;
            end
            S_ACCESS: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Size decode: alignment check, load extraction, store lane enables
    always_comb begin
        mis   = 1'b0;
        rbyte = word[{lane, 3'b000} +: 8];
        rhalf = word[{lane[1], 4'b0000} +: 16];
        rdata = 32'h0;
        be    = 4'b0000;
        wword = wd_q;
        unique case (tam_q)
            2'b00: begin
                rdata = {{24{sg_q & rbyte[7]}}, rbyte};
                be    = 4'b0001 << lane;
                wword = {4{wd_q[7:0]}};
            end
            2'b01: begin
                mis   = lane[0];
                rdata = {{16{sg_q & rhalf[15]}}, rhalf};
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wd_q[15:0]}};
            end
            2'b10: begin
                mis   = (lane != 2'b00);
                rdata = word;
                be    = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    // State register, request latch, wait counter and registered results
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            done      <= 1'b0;
            erro      <= 1'b0;
            dado_Lido <= 32'h0;
            we_q      <= 1'b0;
            sg_q      <= 1'b0;
            tam_q     <= 2'b00;
            addr_q    <= '0;
            wd_q      <= 32'h0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            erro  <= 1'b0;
            if (state == S_IDLE && req) begin
                we_q   <= memWrite;
                sg_q   <= sinal;
                tam_q  <= tamanho;
                addr_q <= endereco;
                wd_q   <= dado_Escrito;
                cnt    <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_ACCESS) begin
                done <= 1'b1;
                erro <= err;
                if (err)
                    dado_Lido <= 32'h0;
                else if (!we_q)
                    dado_Lido <= rdata;
            end
        end
    end

    // Storage array: not cleared by reset; only enabled lanes written
    always_ff @(posedge clock) begin
        if (!reset && state == S_ACCESS && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memoria_de_dados_multiciclo.sv
// Bench for memoria_de_dados_multiciclo: one instance with no wait
// states and one with three, checked against a byte-array model.
module tb_memoria_de_dados_multiciclo;

    localparam int MS = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req3;
    logic        memWrite, sinal;
    logic [1:0]  tamanho;
    logic [31:0] endereco, dado_Escrito;
    logic        ready0, done0, erro0;
    logic        ready3, done3, erro3;
    logic [31:0] rd0, rd3;

    int errors = 0;
    int checks = 0;

    logic [7:0] mm [2][4*MS];

    typedef struct {
        logic        we;
        logic [1:0]  tam;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        eerr;
        logic [31:0] edata;
        logic        cdata;
    } vec_t;

    vec_t tbl [14];

    always #5 clock = ~clock;

    memoria_de_dados_multiciclo #(
        .MEM_SIZE(MS), .ADDR_WIDTH(32), .WAIT_STATES(0)
    ) dut0 (
        .clock(clock), .reset(reset), .req(req0),
        .memWrite(memWrite), .tamanho(tamanho), .sinal(sinal),
        .endereco(endereco), .dado_Escrito(dado_Escrito),
        .ready(ready0), .done(done0), .dado_Lido(rd0), .erro(erro0)
    );

    memoria_de_dados_multiciclo #(
        .MEM_SIZE(MS), .ADDR_WIDTH(32), .WAIT_STATES(3)
    ) dut3 (
        .clock(clock), .reset(reset), .req(req3),
        .memWrite(memWrite), .tamanho(tamanho), .sinal(sinal),
        .endereco(endereco), .dado_Escrito(dado_Escrito),
        .ready(ready3), .done(done3), .dado_Lido(rd3), .erro(erro3)
    );

    function automatic logic rdy(int d);
        return d == 0 ? ready0 : ready3;
    endfunction
    function automatic logic dn(int d);
        return d == 0 ? done0 : done3;
    endfunction
    function automatic logic er(int d);
        return d == 0 ? erro0 : erro3;
    endfunction
    function automatic logic [31:0] rdv(int d);
        return d == 0 ? rd0 : rd3;
    endfunction
    function automatic int ws(int d);
        return d == 0 ? 0 : 3;
    endfunction

    task automatic set_req(int d, logic v);
        if (d == 0) req0 = v;
        else        req3 = v;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic exp_err(logic [1:0] t, logic [31:0] a);
        return (t == 2'd3) || (t == 2'd1 && a[0]) ||
               (t == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(4*MS));
    endfunction

    function automatic logic [31:0] mload(int d, logic [1:0] t,
                                          logic sg, logic [31:0] a);
        int i;
        logic [31:0] v;
        i = int'(a);
        if (t == 2'd0) begin
            v = {24'h0, mm[d][i]};
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else if (t == 2'd1) begin
            v = {16'h0, mm[d][i+1], mm[d][i]};
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = {mm[d][i+3], mm[d][i+2], mm[d][i+1], mm[d][i]};
        end
        return v;
    endfunction

    function automatic void mstore(int d, logic [1:0] t,
                                   logic [31:0] a, logic [31:0] wd);
        int n;
        n = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++)
            mm[d][int'(a) + k] = wd[8*k +: 8];
    endfunction

    // One complete transaction; returns result, error and edge count.
    task automatic do_op(input int d, input logic we, input logic [1:0] t,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic re, output int lat);
        @(negedge clock);
        chk("ready_before_req", {31'h0, rdy(d)}, 32'h1);
        memWrite     = we;
        tamanho      = t;
        sinal        = sg;
        endereco     = a;
        dado_Escrito = wd;
        set_req(d, 1'b1);
        @(posedge clock);
        #1;
        set_req(d, 1'b0);
        memWrite     = $urandom_range(0, 1);
        tamanho      = 2'($urandom_range(0, 3));
        sinal        = $urandom_range(0, 1);
        endereco     = $urandom;
        dado_Escrito = $urandom;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!dn(d) && lat < 40);
        if (!dn(d)) chk("done_timeout", 32'h0, 32'h1);
        rd = rdv(d);
        re = er(d);
    endtask

    // Transaction checked against the model, which then tracks stores.
    task automatic model_op(input int d, input logic we, input logic [1:0] t,
                            input logic sg, input logic [31:0] a,
                            input logic [31:0] wd);
        logic [31:0] rd;
        logic        re, ee;
        int          lat;
        ee = exp_err(t, a);
        do_op(d, we, t, sg, a, wd, rd, re, lat);
        chk("rand_latency", 32'(lat), 32'(ws(d) + 1));
        chk("rand_erro", {31'h0, re}, {31'h0, ee});
        if (ee)
            chk("rand_err_data", rd, 32'h0);
        else if (!we)
            chk("rand_load", rd, mload(d, t, sg, a));
        if (we && !ee)
            mstore(d, t, a, wd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat;
        logic [1:0]  t;
        logic [31:0] a;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h00000080, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        1'b0, 32'hFFFFFF80, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        1'b0, 32'h00000080, 1'b1};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h80ADBEEF, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h0000AAAA, 1'b1, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        1'b1, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h80ADBEEF, 1'b1};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'h11111111, 1'b1, 32'h0,        1'b1};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h80ADBEEF, 1'b1};
        tbl[12] = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        1'b0, 32'hFFFF80AD, 1'b1};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0000BEEF, 1'b1};

        reset = 1'b1;
        req0 = 1'b0;
        req3 = 1'b0;
        memWrite = 1'b0;
        sinal = 1'b0;
        tamanho = 2'd0;
        endereco = 32'h0;
        dado_Escrito = 32'h0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_ready0", {31'h0, ready0}, 32'h1);
        chk("reset_done0", {31'h0, done0}, 32'h0);
        chk("reset_erro0", {31'h0, erro0}, 32'h0);
        chk("reset_data0", rd0, 32'h0);
        chk("reset_ready3", {31'h0, ready3}, 32'h1);
        chk("reset_done3", {31'h0, done3}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_op(0, tbl[i].we, tbl[i].tam, tbl[i].sg, tbl[i].a, tbl[i].wd,
                  rd, re, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d_erro", i), {31'h0, re}, {31'h0, tbl[i].eerr});
            if (tbl[i].cdata)
                chk($sformatf("vec%0d_data", i), rd, tbl[i].edata);
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < MS; w++)
                model_op(d, 1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 150; n++) begin
                t = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
                a = ($urandom_range(0, 19) == 0) ?
                    32'($urandom_range(4*MS, 4*MS + 64)) :
                    32'($urandom_range(0, 4*MS - 1));
                model_op(d, 1'($urandom_range(0, 1)), t,
                         1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        // Three wait states: busy window ignores req, done-cycle req taken
        @(negedge clock);
        memWrite = 1'b0;
        tamanho = 2'd2;
        sinal = 1'b0;
        endereco = 32'h40;
        req3 = 1'b1;
        @(posedge clock);
        #1;
        memWrite = 1'b1;
        dado_Escrito = 32'h0BADBAD0;
        chk("ws3_busy_ready_e0", {31'h0, ready3}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("ws3_busy_ready_e%0d", i), {31'h0, ready3}, 32'h0);
            chk($sformatf("ws3_busy_done_e%0d", i), {31'h0, done3}, 32'h0);
        end
        @(posedge clock);
        #1;
        chk("ws3_done_e4", {31'h0, done3}, 32'h1);
        chk("ws3_ready_e4", {31'h0, ready3}, 32'h1);
        chk("ws3_erro_e4", {31'h0, erro3}, 32'h0);
        chk("ws3_load_e4", rd3, mload(1, 2'd2, 1'b0, 32'h40));
        dado_Escrito = 32'hCAFEF00D;
        @(posedge clock);
        #1;
        req3 = 1'b0;
        chk("ws3_b2b_accepted", {31'h0, ready3}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("ws3_b2b_done_%0d", i), {31'h0, done3},
                (i == 3) ? 32'h1 : 32'h0);
        end
        mstore(1, 2'd2, 32'h40, 32'hCAFEF00D);
        model_op(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        // Reset in the middle of the wait window drops the pending store
        @(negedge clock);
        memWrite = 1'b1;
        tamanho = 2'd2;
        endereco = 32'h20;
        dado_Escrito = 32'h12345678;
        req3 = 1'b1;
        @(posedge clock);
        #1;
        req3 = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_mid_ready", {31'h0, ready3}, 32'h1);
        chk("rst_mid_done", {31'h0, done3}, 32'h0);
        chk("rst_mid_data", rd3, 32'h0);
        repeat (4) begin
            @(posedge clock);
            #1;
            chk("rst_mid_no_done", {31'h0, done3}, 32'h0);
        end
        model_op(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        model_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
